// File: rtl/instr_seq_pkg.sv
// Shared constants for the multi-cycle instruction sequencer: state encoding,
// halt opcode, multiplier iteration count and datapath widths.
package instr_seq_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] HALT_OP_DEFAULT    = 4'b1111;
  localparam int              MUL_CYCLES_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MUL    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

endpackage

// File: rtl/instr_sequencer_if.sv
// Decode-side inputs and datapath strobes of the sequencer. The sequencer
// drives the strobes through the master modport; the datapath uses slave.
interface instr_sequencer_if;
  import instr_seq_pkg::*;

  logic              run;
  logic [OP_W-1:0]   opcode;
  logic              mul_flag;
  logic              regwrite_flag;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              ir_load;
  logic              pc_en;
  logic              rf_we;
  logic              mul_sel;
  logic [DATA_W-1:0] mul_result;
  logic              busy;
  logic              halted;
  logic [DATA_W-1:0] retired;

  modport master (
    input  run, opcode, mul_flag, regwrite_flag, mul_a, mul_b,
    output ir_load, pc_en, rf_we, mul_sel, mul_result, busy, halted, retired
  );

  modport slave (
    output run, opcode, mul_flag, regwrite_flag, mul_a, mul_b,
    input  ir_load, pc_en, rf_we, mul_sel, mul_result, busy, halted, retired
  );

endinterface

// File: rtl/instr_sequencer_mul.sv
// Iterative shift-add multiplier, one bit of the multiplier per cycle.
// done pulses during the final iteration with product already valid.
module shift_add_mul16
  import instr_seq_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  logic              active;

  // product is combinational so the owner can latch it on the same edge
  // that ends the last iteration, keeping MUL at exactly MUL_CYCLES cycles.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = active && (cnt == CNT_W'(MUL_CYCLES - 1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXEC/(MUL)/WB sequencer for the 16-bit core. All strobes are
// decoded from registered state so they are clean single-cycle pulses.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter logic [OP_W-1:0] HALT_OP    = HALT_OP_DEFAULT,
  parameter int              MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  instr_sequencer_if.master bus
);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              wb_we_q;
  logic              wb_mul_q;
  logic [DATA_W-1:0] mul_result_q;
  logic [DATA_W-1:0] retired_q;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              is_halt;

  assign is_halt   = (bus.opcode == HALT_OP);
  assign mul_start = (state == ST_EXEC) && !is_halt && bus.mul_flag;

  shift_add_mul16 #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.mul_a),
    .b       (bus.mul_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.run) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (is_halt)           state_next = ST_HALT;
        else if (bus.mul_flag) state_next = ST_MUL;
        else                   state_next = ST_WB;
      end
      ST_MUL:    if (mul_done) state_next = ST_WB;
      ST_WB:     state_next = bus.run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Write-back qualifiers are captured in EXEC so the WB strobes depend only
  // on registered state, not on whatever Decode presents during WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wb_we_q      <= 1'b0;
      wb_mul_q     <= 1'b0;
      mul_result_q <= '0;
      retired_q    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_EXEC) begin
        wb_we_q  <= bus.regwrite_flag;
        wb_mul_q <= bus.mul_flag;
      end
      if (mul_done) mul_result_q <= mul_product;
      if (state == ST_WB) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.ir_load    = (state == ST_FETCH);
  assign bus.pc_en      = (state == ST_WB);
  assign bus.rf_we      = (state == ST_WB) && wb_we_q;
  assign bus.mul_sel    = (state == ST_WB) && wb_mul_q;
  assign bus.busy       = (state != ST_IDLE) && (state != ST_HALT);
  assign bus.halted     = (state == ST_HALT);
  assign bus.mul_result = mul_result_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table of single instructions
// plus hand-written reset, mid-MUL reset, retired wrap and HALT sequences.
module tb_instr_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  opcode;
    logic        mul_flag;
    logic        regwrite_flag;
    logic [15:0] a;
    logic [15:0] b;
    int          exp_cycles;
    logic        exp_rf_we;
    logic        exp_mul_sel;
    logic [15:0] exp_result;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_retired;
  int          obs_cycles;
  int          obs_extra;
  logic        obs_fetch;
  logic        obs_wb;
  logic        obs_rf_we;
  logic        obs_mul_sel;
  logic [15:0] obs_result;
  logic        obs_parked;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction from IDLE, dropping run during DECODE so it parks.
  task automatic applyStimulus(input vec_t v);
    bus.opcode        = v.opcode;
    bus.mul_flag      = v.mul_flag;
    bus.regwrite_flag = v.regwrite_flag;
    bus.mul_a         = v.a;
    bus.mul_b         = v.b;
    bus.run           = 1'b1;
    tick();
    obs_cycles = 1;
    obs_fetch  = bus.ir_load;
    tick();
    obs_cycles = 2;
    bus.run    = 1'b0;
    obs_extra  = 0;
    while (!bus.pc_en && obs_cycles < 40) begin
      if (bus.ir_load || bus.rf_we || bus.mul_sel || !bus.busy) obs_extra++;
      tick();
      obs_cycles++;
    end
    obs_wb      = bus.pc_en;
    obs_rf_we   = bus.rf_we;
    obs_mul_sel = bus.mul_sel;
    obs_result  = bus.mul_result;
    obs_parked  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy || bus.ir_load || bus.pc_en) obs_parked = 1'b0;
    end
  endtask

  task automatic checkOutput(input vec_t v);
    exp_retired = exp_retired + 16'd1;
    check({v.name, " fetch"},   {31'd0, obs_fetch}, 32'd1);
    check({v.name, " wb"},      {31'd0, obs_wb}, 32'd1);
    check({v.name, " cycles"},  obs_cycles, v.exp_cycles);
    check({v.name, " rf_we"},   {31'd0, obs_rf_we}, {31'd0, v.exp_rf_we});
    check({v.name, " mul_sel"}, {31'd0, obs_mul_sel}, {31'd0, v.exp_mul_sel});
    check({v.name, " result"},  {16'd0, obs_result}, {16'd0, v.exp_result});
    check({v.name, " stray"},   obs_extra, 0);
    check({v.name, " parked"},  {31'd0, obs_parked}, 32'd1);
    check({v.name, " retired"}, {16'd0, bus.retired}, {16'd0, exp_retired});
  endtask

  initial begin
    vec_t wrap_vec;
    vec_t halt_vec;
    int   bad;

    checks = 0;
    errors = 0;
    exp_retired = 16'd0;

    vecs[0] = '{"add",      4'h1, 1'b0, 1'b1, 16'h1111, 16'h2222,  4, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{"store",    4'h2, 1'b0, 1'b0, 16'h0000, 16'h0000,  4, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{"mul_a",    4'h3, 1'b1, 1'b1, 16'h0123, 16'h0045, 20, 1'b1, 1'b1, 16'h4E6F};
    vecs[3] = '{"mul_ffff", 4'h3, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 20, 1'b1, 1'b1, 16'h0001};
    vecs[4] = '{"add_hold", 4'h1, 1'b0, 1'b1, 16'h5555, 16'h0003,  4, 1'b1, 1'b0, 16'h0001};
    vecs[5] = '{"mul_nowe", 4'h3, 1'b1, 1'b0, 16'h0003, 16'h8001, 20, 1'b0, 1'b1, 16'h8003};

    // Reset held two cycles with run high.
    rst               = 1'b1;
    bus.run           = 1'b1;
    bus.opcode        = 4'h1;
    bus.mul_flag      = 1'b0;
    bus.regwrite_flag = 1'b1;
    bus.mul_a         = 16'h0000;
    bus.mul_b         = 16'h0000;
    tick();
    tick();
    check("rst strobes", {28'd0, bus.ir_load, bus.pc_en, bus.rf_we, bus.mul_sel}, 32'd0);
    check("rst busy_halted", {30'd0, bus.busy, bus.halted}, 32'd0);
    check("rst mul_result", {16'd0, bus.mul_result}, 32'd0);
    check("rst retired", {16'd0, bus.retired}, 32'd0);

    // Back-to-back ADDs with run held high.
    rst = 1'b0;
    tick();
    check("b2b ir_load@1", {31'd0, bus.ir_load}, 32'd1);
    tick();
    tick();
    check("b2b quiet@3", {29'd0, bus.ir_load, bus.pc_en, bus.rf_we}, 32'd0);
    tick();
    check("b2b wb@4", {30'd0, bus.pc_en, bus.rf_we}, 32'd3);
    tick();
    check("b2b ir_load@5", {31'd0, bus.ir_load}, 32'd1);
    check("b2b retired1", {16'd0, bus.retired}, 32'd1);
    bus.run = 1'b0;
    tick();
    tick();
    tick();
    check("b2b wb@8", {31'd0, bus.pc_en}, 32'd1);
    tick();
    check("b2b parked", {30'd0, bus.busy, bus.ir_load}, 32'd0);
    check("b2b retired2", {16'd0, bus.retired}, 32'd2);
    exp_retired = 16'd2;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Reset on the 7th MUL cycle discards the partial product.
    bus.opcode        = 4'h3;
    bus.mul_flag      = 1'b1;
    bus.regwrite_flag = 1'b1;
    bus.mul_a         = 16'h0002;
    bus.mul_b         = 16'h0003;
    bus.run           = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("midmul busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midmul idle", {30'd0, bus.busy, bus.rf_we}, 32'd0);
    check("midmul result", {16'd0, bus.mul_result}, 32'd0);
    check("midmul retired", {16'd0, bus.retired}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy || bus.rf_we || bus.pc_en || bus.mul_result != 16'h0000) bad++;
    end
    check("midmul stays idle", bad, 0);

    // Retired counter wrap.
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    wrap_vec = '{"wrap", 4'h1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4, 1'b1, 1'b0, 16'h0000};
    applyStimulus(wrap_vec);
    checkOutput(wrap_vec);

    // HALT opcode with mul_flag: HALT wins and is absorbing.
    halt_vec = '{"halt", 4'hF, 1'b1, 1'b1, 16'h0007, 16'h0009, 0, 1'b0, 1'b0, 16'h0000};
    bus.opcode        = halt_vec.opcode;
    bus.mul_flag      = halt_vec.mul_flag;
    bus.regwrite_flag = halt_vec.regwrite_flag;
    bus.mul_a         = halt_vec.a;
    bus.mul_b         = halt_vec.b;
    bus.run           = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("halt entered", {30'd0, bus.halted, bus.busy}, 32'd2);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bus.halted || bus.ir_load || bus.pc_en || bus.rf_we || bus.mul_sel ||
          bus.retired != exp_retired || bus.mul_result != 16'h0000) bad++;
    end
    check("halt absorbing", bad, 0);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.run = 1'b0;
    check("halt rst", {30'd0, bus.halted, bus.busy}, 32'd0);
    tick();
    check("halt rst idle", {30'd0, bus.halted, bus.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
